// File: rtl/ex_stage.sv
// EX pipeline stage: ALU, EX/MEM register and optional iterative HI/LO mul/div unit.
// Define EX_STAGE_MULDIV_EN to build the multiply/divide unit; otherwise MFHI/MFLO read 0.
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  wb_EX,
    input  logic [2:0]  m_EX,
    input  logic [3:0]  alu_op,
    input  logic        alu_src,
    input  logic        reg_dst,
    input  logic [1:0]  md_op,
    input  logic [31:0] read_data_1,
    input  logic [31:0] read_data_2,
    input  logic [31:0] sign_ext_imm,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    output logic [1:0]  wb_MEM,
    output logic [2:0]  m_MEM,
    output logic        zero,
    output logic [31:0] address_MEM,
    output logic [31:0] write_data_mem,
    output logic [4:0]  write_register_ex,
    output logic        stall,
    output logic        md_busy
);

    logic [31:0] op_a, op_b, result, hi_val, lo_val;
    logic [4:0]  shamt;

    assign op_a  = read_data_1;
    assign op_b  = alu_src ? sign_ext_imm : read_data_2;
    assign shamt = sign_ext_imm[10:6];

    always_comb begin
        result = 32'd0;
        case (alu_op)
            4'd0:  result = op_a & op_b;
            4'd1:  result = op_a | op_b;
            4'd2:  result = op_a + op_b;
            4'd3:  result = op_a - op_b;
            4'd4:  result = {31'd0, $signed(op_a) < $signed(op_b)};
            4'd5:  result = ~(op_a | op_b);
            4'd6:  result = op_a ^ op_b;
            4'd7:  result = op_b << shamt;
            4'd8:  result = op_b >> shamt;
            4'd9:  result = $signed(op_b) >>> shamt;
            4'd10: result = {31'd0, op_a < op_b};
            4'd11: result = op_b << 16;
            4'd12: result = hi_val;
            4'd13: result = lo_val;
            default: result = 32'd0;
        endcase
    end

`ifdef EX_STAGE_MULDIV_EN
    localparam logic [1:0] MD_MULTU = 2'b10;
    localparam logic [1:0] MD_DIV   = 2'b11;

    logic [31:0] hi_q, lo_q, acc_q, acc_d, quo_q, quo_d, dvs_q;
    logic [31:0] hi_fin, lo_fin, a_mag, b_mag;
    logic [4:0]  cnt_q;
    logic [1:0]  op_q;
    logic        busy_q, neg_a_q, neg_b_q, dz_q, signed_op;
    logic [32:0] sum, rem_sh, rem_diff;
    logic [63:0] prod_fix;

    assign signed_op = (md_op != MD_MULTU);
    assign a_mag     = (signed_op && read_data_1[31]) ? -read_data_1 : read_data_1;
    assign b_mag     = (signed_op && read_data_2[31]) ? -read_data_2 : read_data_2;

    // Both ops work on magnitudes: shift-add multiply or restoring divide, one bit per cycle.
    always_comb begin
        sum      = 33'd0;
        rem_sh   = 33'd0;
        rem_diff = 33'd0;
        acc_d    = acc_q;
        quo_d    = quo_q;
        if (op_q == MD_DIV) begin
            rem_sh   = {acc_q, quo_q[31]};
            rem_diff = rem_sh - {1'b0, dvs_q};
            if (rem_sh >= {1'b0, dvs_q}) begin
                acc_d = rem_diff[31:0];
                quo_d = {quo_q[30:0], 1'b1};
            end else begin
                acc_d = rem_sh[31:0];
                quo_d = {quo_q[30:0], 1'b0};
            end
        end else begin
            sum   = {1'b0, acc_q} + (quo_q[0] ? {1'b0, dvs_q} : 33'd0);
            acc_d = sum[32:1];
            quo_d = {sum[0], quo_q[31:1]};
        end
    end

    // A zero divisor leaves the dividend magnitude in acc, so only LO needs overriding.
    always_comb begin
        prod_fix = {acc_d, quo_d};
        if (neg_a_q ^ neg_b_q)
            prod_fix = -prod_fix;
        hi_fin = prod_fix[63:32];
        lo_fin = prod_fix[31:0];
        if (op_q == MD_DIV) begin
            hi_fin = neg_a_q ? -acc_d : acc_d;
            lo_fin = dz_q ? 32'hFFFF_FFFF : ((neg_a_q ^ neg_b_q) ? -quo_d : quo_d);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            acc_q   <= 32'd0;
            quo_q   <= 32'd0;
            dvs_q   <= 32'd0;
            cnt_q   <= 5'd0;
            op_q    <= 2'b00;
            busy_q  <= 1'b0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            dz_q    <= 1'b0;
        end else if (busy_q) begin
            acc_q <= acc_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - 5'd1;
            if (cnt_q == 5'd0) begin
                busy_q <= 1'b0;
                hi_q   <= hi_fin;
                lo_q   <= lo_fin;
            end
        end else if (md_op != 2'b00) begin
            busy_q  <= 1'b1;
            cnt_q   <= 5'd31;
            op_q    <= md_op;
            neg_a_q <= signed_op & read_data_1[31];
            neg_b_q <= signed_op & read_data_2[31];
            dz_q    <= (read_data_2 == 32'd0);
            acc_q   <= 32'd0;
            quo_q   <= a_mag;
            dvs_q   <= b_mag;
        end
    end

    assign hi_val  = hi_q;
    assign lo_val  = lo_q;
    assign md_busy = busy_q;
    assign stall   = busy_q && ((md_op != 2'b00) || (alu_op == 4'd12) || (alu_op == 4'd13));
`else
    logic unused_md_op;

    assign unused_md_op = ^md_op;
    assign hi_val       = 32'd0;
    assign lo_val       = 32'd0;
    assign md_busy      = 1'b0;
    assign stall        = 1'b0;
`endif

    logic [1:0]  wb_q;
    logic [2:0]  m_q;
    logic        zero_q;
    logic [31:0] addr_q, wdata_q;
    logic [4:0]  wreg_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_q    <= 2'b00;
            m_q     <= 3'b000;
            zero_q  <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wreg_q  <= 5'd0;
        end else begin
            wb_q    <= stall ? 2'b00 : wb_EX;
            m_q     <= stall ? 3'b000 : m_EX;
            zero_q  <= (result == 32'd0);
            addr_q  <= result;
            wdata_q <= read_data_2;
            wreg_q  <= reg_dst ? rd : rt;
        end
    end

    assign wb_MEM            = wb_q;
    assign m_MEM             = m_q;
    assign zero              = zero_q;
    assign address_MEM       = addr_q;
    assign write_data_mem    = wdata_q;
    assign write_register_ex = wreg_q;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed scenarios plus randomized instructions against a behavioural model.
module tb_ex_stage;

`ifdef EX_STAGE_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  wb_EX, md_op, wb_MEM;
    logic [2:0]  m_EX, m_MEM;
    logic [3:0]  alu_op;
    logic        alu_src, reg_dst, zero, stall, md_busy;
    logic [31:0] read_data_1, read_data_2, sign_ext_imm, address_MEM, write_data_mem;
    logic [4:0]  rt, rd, write_register_ex;

    ex_stage dut (
        .clk(clk), .rst(rst), .wb_EX(wb_EX), .m_EX(m_EX), .alu_op(alu_op),
        .alu_src(alu_src), .reg_dst(reg_dst), .md_op(md_op),
        .read_data_1(read_data_1), .read_data_2(read_data_2), .sign_ext_imm(sign_ext_imm),
        .rt(rt), .rd(rd), .wb_MEM(wb_MEM), .m_MEM(m_MEM), .zero(zero),
        .address_MEM(address_MEM), .write_data_mem(write_data_mem),
        .write_register_ex(write_register_ex), .stall(stall), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    // Model of architectural HI/LO and of the pending result of the running operation.
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    int          busy_left;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, b,
                                            input int sh, input logic [31:0] hi, lo);
        int sa, sb;
        sa = int'(a);
        sb = int'(b);
        case (op)
            0: return a & b;
            1: return a | b;
            2: return a + b;
            3: return a - b;
            4: return (sa < sb) ? 32'd1 : 32'd0;
            5: return ~(a | b);
            6: return a ^ b;
            7: return b << sh;
            8: return b >> sh;
            9: return 32'(sb >>> sh);
            10: return (a < b) ? 32'd1 : 32'd0;
            11: return b * 32'd65536;
            12: return hi;
            13: return lo;
            default: return 32'd0;
        endcase
    endfunction

    function automatic void md_ref(input logic [1:0] op, input logic [31:0] a, b,
                                   output logic [31:0] hi, lo);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'd0;
        case (op)
            2'b01: p = 64'(sa * sb);
            2'b10: p = {32'd0, a} * {32'd0, b};
            default: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
        endcase
        hi = p[63:32];
        lo = p[31:0];
    endfunction

    task automatic issue(input logic [3:0] aop, input logic [1:0] mop,
                         input logic [31:0] a, b, imm, input logic src);
        alu_op       = aop;
        md_op        = mop;
        read_data_1  = a;
        read_data_2  = b;
        sign_ext_imm = imm;
        alu_src      = src;
        wb_EX        = 2'($urandom_range(0, 3));
        m_EX         = 3'($urandom_range(0, 7));
        rt           = 5'($urandom_range(0, 31));
        rd           = 5'($urandom_range(0, 31));
        reg_dst      = 1'($urandom_range(0, 1));
    endtask

    // One clock: checks stall before the edge, EX/MEM contents and md_busy after it.
    task automatic tick();
        logic        e_stall;
        logic [31:0] e_res, e_wd;
        logic [4:0]  e_wr;
        logic [1:0]  e_wb;
        logic [2:0]  e_m;
        #1;
        e_stall = (busy_left > 0) && (md_op != 2'b00 || alu_op == 4'd12 || alu_op == 4'd13);
        chk("stall", {31'd0, stall}, {31'd0, e_stall});
        e_res = alu_ref(alu_op, read_data_1, alu_src ? sign_ext_imm : read_data_2,
                        int'(sign_ext_imm[10:6]), m_hi, m_lo);
        e_wd  = read_data_2;
        e_wr  = reg_dst ? rd : rt;
        e_wb  = e_stall ? 2'b00 : wb_EX;
        e_m   = e_stall ? 3'b000 : m_EX;
        if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (MD_EN && md_op != 2'b00) begin
            md_ref(md_op, read_data_1, read_data_2, p_hi, p_lo);
            busy_left = 32;
        end
        @(posedge clk);
        #1;
        chk("wb_MEM", {30'd0, wb_MEM}, {30'd0, e_wb});
        chk("m_MEM", {29'd0, m_MEM}, {29'd0, e_m});
        chk("md_busy", {31'd0, md_busy}, {31'd0, busy_left > 0});
        if (!e_stall) begin
            chk("address_MEM", address_MEM, e_res);
            chk("zero", {31'd0, zero}, {31'd0, e_res == 32'd0});
            chk("write_data_mem", write_data_mem, e_wd);
            chk("write_register_ex", {27'd0, write_register_ex}, {27'd0, e_wr});
        end
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_wb"}, {30'd0, wb_MEM}, 32'd0);
        chk({tag, "_m"}, {29'd0, m_MEM}, 32'd0);
        chk({tag, "_zero"}, {31'd0, zero}, 32'd0);
        chk({tag, "_addr"}, address_MEM, 32'd0);
        chk({tag, "_wdata"}, write_data_mem, 32'd0);
        chk({tag, "_wreg"}, {27'd0, write_register_ex}, 32'd0);
        chk({tag, "_busy"}, {31'd0, md_busy}, 32'd0);
        chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        busy_left = 0;
    endtask

    // Holds a HI/LO read until it stops stalling, then lets it through.
    task automatic read_after_md(input logic [3:0] aop, output int stalls);
        stalls = 0;
        for (int i = 0; i < 40; i++) begin
            issue(aop, 2'b00, 32'd0, 32'd0, 32'd0, 1'b0);
            #1;
            if (!stall) break;
            stalls++;
            tick();
        end
        tick();
    endtask

    int          n_st;
    logic [31:0] ra, rb;

    initial begin
        rst = 1'b1;
        issue(4'd0, 2'b00, 32'd0, 32'd0, 32'd0, 1'b0);
        #1;
        reset_check("por");
        #20;
        rst = 1'b0;

        // ADD 5+7 into rd=9
        issue(4'd2, 2'b00, 32'd5, 32'd7, 32'd0, 1'b0);
        reg_dst = 1'b1;
        rd      = 5'd9;
        tick();
        chk("add_addr", address_MEM, 32'd12);
        chk("add_zero", {31'd0, zero}, 32'd0);
        chk("add_wreg", {27'd0, write_register_ex}, 32'd9);

        // SUB equal operands
        issue(4'd3, 2'b00, 32'h1234, 32'h1234, 32'd0, 1'b0);
        wb_EX = 2'b10;
        tick();
        chk("sub_addr", address_MEM, 32'd0);
        chk("sub_zero", {31'd0, zero}, 32'd1);
        chk("sub_wb", {30'd0, wb_MEM}, 32'd2);

        // MULT -3 x 4, then MFLO / MFHI
        issue(4'd0, 2'b01, 32'hFFFF_FFFD, 32'd4, 32'd0, 1'b0);
        tick();
        read_after_md(4'd13, n_st);
        chk("mult_stall_cycles", n_st, MD_EN ? 32'd32 : 32'd0);
        chk("mult_lo", address_MEM, MD_EN ? 32'hFFFF_FFF4 : 32'd0);
        issue(4'd12, 2'b00, 32'd0, 32'd0, 32'd0, 1'b0);
        tick();
        chk("mult_hi", address_MEM, MD_EN ? 32'hFFFF_FFFF : 32'd0);

        // DIV 7/0
        issue(4'd0, 2'b11, 32'd7, 32'd0, 32'd0, 1'b0);
        tick();
        read_after_md(4'd13, n_st);
        chk("div0_stall_cycles", n_st, MD_EN ? 32'd32 : 32'd0);
        chk("div0_lo", address_MEM, MD_EN ? 32'hFFFF_FFFF : 32'd0);
        issue(4'd12, 2'b00, 32'd0, 32'd0, 32'd0, 1'b0);
        tick();
        chk("div0_hi", address_MEM, MD_EN ? 32'd7 : 32'd0);

        // DIV -7/2
        issue(4'd0, 2'b11, 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b0);
        tick();
        read_after_md(4'd13, n_st);
        chk("div_neg_lo", address_MEM, MD_EN ? 32'hFFFF_FFFD : 32'd0);
        issue(4'd12, 2'b00, 32'd0, 32'd0, 32'd0, 1'b0);
        tick();
        chk("div_neg_hi", address_MEM, MD_EN ? 32'hFFFF_FFFF : 32'd0);

        // MULTU followed by an independent ADD
        issue(4'd0, 2'b10, 32'hDEAD_BEEF, 32'h1234_5678, 32'd0, 1'b0);
        tick();
        issue(4'd2, 2'b00, 32'd1, 32'd1, 32'd0, 1'b0);
        tick();
        chk("multu_add_addr", address_MEM, 32'd2);
        chk("multu_add_busy", {31'd0, md_busy}, {31'd0, MD_EN});
        read_after_md(4'd12, n_st);
        issue(4'd13, 2'b00, 32'd0, 32'd0, 32'd0, 1'b0);
        tick();

        // Randomized instruction stream
        for (int i = 0; i < 500; i++) begin
            case ($urandom_range(0, 3))
                0: begin ra = $urandom(); rb = ra; end
                1: begin ra = 32'($urandom_range(0, 20)) - 32'd10; rb = 32'($urandom_range(0, 20)) - 32'd10; end
                2: begin ra = $urandom(); rb = 32'($urandom_range(0, 3)); end
                default: begin ra = $urandom(); rb = $urandom(); end
            endcase
            issue(4'($urandom_range(0, 15)),
                  ($urandom_range(0, 11) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                  ra, rb, $urandom(), 1'($urandom_range(0, 1)));
            tick();
        end
        for (int i = 0; i < 34; i++) begin
            issue(4'd2, 2'b00, $urandom(), $urandom(), 32'd0, 1'b0);
            tick();
        end
        issue(4'd12, 2'b00, 32'd0, 32'd0, 32'd0, 1'b0);
        tick();
        issue(4'd13, 2'b00, 32'd0, 32'd0, 32'd0, 1'b0);
        tick();

        // Reset in the middle of a MULT
        issue(4'd0, 2'b01, 32'h0001_2345, 32'h0000_0777, 32'd0, 1'b0);
        tick();
        for (int i = 0; i < 10; i++) begin
            issue(4'd1, 2'b00, 32'h8000_0000, 32'd1, 32'd0, 1'b0);
            tick();
        end
        #3;
        rst = 1'b1;
        #1;
        reset_check("midrst");
        @(posedge clk);
        #2;
        rst = 1'b0;
        issue(4'd12, 2'b00, 32'd0, 32'd0, 32'd0, 1'b0);
        tick();
        chk("midrst_mfhi", address_MEM, 32'd0);
        issue(4'd13, 2'b00, 32'd0, 32'd0, 32'd0, 1'b0);
        tick();
        chk("midrst_mflo", address_MEM, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL provide: clk  in  1  pipeline clock, rising edge.
REQ-002 SHALL provide: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL provide: wb_EX  in  2  writeback controls; m_EX  in  3  memory controls (m[1] read, m[0] write).
REQ-004 SHALL provide: alu_op  in  4  ALU select; alu_src  in  1  operand B = immediate; reg_dst  in  1  destination = rd.
REQ-005 SHALL provide: md_op  in  2  00 none, 01 MULT, 10 MULTU, 11 DIV.
REQ-006 SHALL provide: read_data_1, read_data_2, sign_ext_imm  in  32 each; rt, rd  in  5 each.
REQ-007 SHALL provide: wb_MEM  out  2; m_MEM  out  3; zero  out  1; address_MEM, write_data_mem  out  32; write_register_ex  out  5. All are registered EX/MEM outputs.
REQ-008 SHALL provide: stall  out  1  upstream holds its instruction while this output is high (combinational).
REQ-009 SHALL provide: md_busy  out  1  multiply/divide unit running (registered).

Function
REQ-010 ALU operation codes SHALL be: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT signed, 5 NOR, 6 XOR, 7 SLL, 8 SRL, 9 SRA, 10 SLTU, 11 LUI (B<<16), 12 MFHI, 13 MFLO; codes 14–15 SHALL produce 0.
REQ-011 Operand A SHALL be read_data_1. Operand B SHALL be sign_ext_imm when alu_src=1, otherwise read_data_2. The shift amount SHALL be sign_ext_imm[10:6].
REQ-012 ADD and SUB SHALL wrap modulo 2^32 and SHALL raise no overflow indication.
REQ-013 On each rising clk edge with stall=0, the outputs SHALL update as follows: address_MEM = result; zero = (result==0); write_data_mem = read_data_2; write_register_ex = reg_dst ? rd : rt; wb_MEM = wb_EX; m_MEM = m_EX. Latency is 1 cycle.
REQ-014 While stall=1, the EX/MEM register SHALL load a bubble (wb_MEM=0, m_MEM=0, other fields don't-care) and SHALL NOT start any md operation.
REQ-015 stall SHALL equal md_busy AND (md_op≠0 OR alu_op∈{12,13}). Independent instructions SHALL proceed while md_busy=1.
REQ-016 When md_op≠0 and md_busy=0, the unit SHALL capture the operands and set md_busy on the next edge. The computation SHALL be iterative and run exactly 32 cycles with md_busy=1.
REQ-017 HI/LO SHALL be written on the final iteration edge. md_busy SHALL fall on that same edge. An MFHI/MFLO held by the stall SHALL read the new value in the following cycle.
REQ-018 MULT SHALL produce a signed 64-bit product and MULTU an unsigned one, with HI = [63:32] and LO = [31:0].
REQ-019 DIV SHALL be signed: LO = quotient truncated toward zero; HI = remainder carrying the sign of the dividend.
REQ-020 DIV by 0 SHALL set LO=0xFFFFFFFF and HI=dividend, with the same 32-cycle duration.
REQ-021 The md instruction itself SHALL pass to EX/MEM normally in its issue cycle, with its own wb/m controls.

Reset
REQ-022 rst=1 SHALL immediately clear: wb_MEM, m_MEM, zero, address_MEM, write_data_mem, write_register_ex, HI, LO, md_busy, and the iteration counter.
REQ-023 Reset during an md operation SHALL abort it, leaving HI=LO=0. stall SHALL read 0 while rst=1.
REQ-024 After rst falls, the first rising edge SHALL behave as a normal issue cycle.

Configuration
REQ-025 Macro EX_STAGE_MULDIV_EN defined: the HI/LO unit behaves as REQ-015–REQ-021.
REQ-026 Macro EX_STAGE_MULDIV_EN undefined: no HI/LO or iteration logic is built; md_op is ignored; md_busy and stall are tied 0; MFHI/MFLO return 0.

Verification
REQ-027 ADD: read_data_1=5, read_data_2=7, alu_src=0, alu_op=2, reg_dst=1, rd=9 -> next edge: address_MEM=12, zero=0, write_register_ex=9.
REQ-028 SUB of equal operands 0x1234, wb_EX=2'b10 -> address_MEM=0, zero=1, wb_MEM=2'b10.
REQ-029 MULT of 0xFFFFFFFD by 4 (-3×4), then MFLO issued next cycle -> stall=1 for 32 cycles with bubbles in EX/MEM; MFLO then gives 0xFFFFFFF4 and MFHI gives 0xFFFFFFFF.
REQ-030 DIV 7/0 -> after 32 cycles LO=0xFFFFFFFF, HI=7. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-031 MULTU issued, then ADD 1+1 on the next cycle -> no stall; address_MEM=2 on the next edge; md_busy stays 1.
REQ-032 rst pulsed at iteration 10 of a MULT -> all outputs 0 at once, md_busy=0, and MFHI after reset yields 0.
